// File: rtl/sample_rom_ctrl_if.sv
// Sample ROM port bundle: MCU-side address/data handshake plus the SDRAM read channel.
// "slave" is the controller's view; "master" is the MCU/SDRAM side driving it.
`timescale 1ns/1ps
interface sample_rom_ctrl_if #(parameter int ROM_AW = 25);
    logic [1:0]        sample_addr_wr;
    logic [7:0]        sample_addr;
    logic              sample_inc;
    logic [7:0]        sample_rom_data;
    logic              sample_ready;
    logic              rom_req;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ack;
    logic [15:0]       rom_data;

    modport master (
        output sample_addr_wr, sample_addr, sample_inc, rom_ack, rom_data,
        input  sample_rom_data, sample_ready, rom_req, rom_addr
    );
    modport slave (
        input  sample_addr_wr, sample_addr, sample_inc, rom_ack, rom_data,
        output sample_rom_data, sample_ready, rom_req, rom_addr
    );
endinterface

// File: rtl/sample_rom_ctrl.sv
// 8051 sample ROM fetch controller: tracks the MCU sample address and reads 16-bit words from SDRAM.
// Optional one-word cache enabled by defining SAMPLE_WORD_CACHE_EN.
`timescale 1ns/1ps
module sample_rom_ctrl #(
    parameter int                ROM_AW   = 25,
    parameter logic [ROM_AW-1:0] ROM_BASE = '0
) (
    input logic               CLK_32M,
    input logic               reset,
    sample_rom_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {BOOT, IDLE, REQ} state_t;

    state_t            state, state_nxt;
    logic [15:0]       addr, addr_nxt;
    logic [15:0]       word, word_nxt;
    logic              stale, stale_nxt;
    logic              req, req_nxt;
    logic              ready, ready_nxt;
    logic [ROM_AW-1:0] rom_addr_r, rom_addr_nxt, fetch_addr;
    logic [7:0]        data_r, data_nxt;
    logic              ev, hit, word_ld;

    // A write takes precedence over a same-cycle increment.
    always_comb begin
        ev       = (bus.sample_addr_wr != 2'b00) || bus.sample_inc;
        addr_nxt = addr;
        case (bus.sample_addr_wr)
            2'b11:   addr_nxt = {bus.sample_addr, bus.sample_addr};
            2'b01:   addr_nxt = {addr[15:8], bus.sample_addr};
            2'b10:   addr_nxt = {bus.sample_addr, addr[7:0]};
            default: if (bus.sample_inc) addr_nxt = addr + 16'd1;
        endcase
    end

    assign fetch_addr = ROM_BASE + ROM_AW'({addr_nxt[15:1], 1'b0});

`ifdef SAMPLE_WORD_CACHE_EN
    logic [14:0] tag;
    logic        tag_vld;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            tag     <= '0;
            tag_vld <= 1'b0;
        end else if (word_ld) begin
            tag     <= addr[15:1];
            tag_vld <= 1'b1;
        end
    end

    assign hit = tag_vld && (addr_nxt[15:1] == tag);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        stale_nxt    = stale;
        req_nxt      = req;
        ready_nxt    = ready;
        rom_addr_nxt = rom_addr_r;
        word_nxt     = word;
        word_ld      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt    = REQ;
                req_nxt      = 1'b1;
                stale_nxt    = 1'b0;
                rom_addr_nxt = fetch_addr;
            end
            IDLE: begin
                if (ev && !hit) begin
                    state_nxt    = REQ;
                    req_nxt      = 1'b1;
                    ready_nxt    = 1'b0;
                    rom_addr_nxt = fetch_addr;
                end
            end
            REQ: begin
                if (!req) begin
                    // one-cycle gap after a stale ack; re-issue for the latest address
                    req_nxt      = 1'b1;
                    rom_addr_nxt = fetch_addr;
                end else if (bus.rom_ack) begin
                    if (stale || ev) begin
                        stale_nxt = 1'b0;
                        req_nxt   = 1'b0;
                    end else begin
                        word_nxt  = bus.rom_data;
                        word_ld   = 1'b1;
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                        ready_nxt = 1'b1;
                    end
                end else if (ev) begin
                    stale_nxt = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
        data_nxt = addr_nxt[0] ? word_nxt[15:8] : word_nxt[7:0];
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            addr       <= '0;
            word       <= '0;
            stale      <= 1'b0;
            req        <= 1'b0;
            ready      <= 1'b0;
            rom_addr_r <= ROM_BASE;
            data_r     <= '0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            word       <= word_nxt;
            stale      <= stale_nxt;
            req        <= req_nxt;
            ready      <= ready_nxt;
            rom_addr_r <= rom_addr_nxt;
            data_r     <= data_nxt;
        end
    end

    assign bus.rom_req         = req;
    assign bus.rom_addr        = rom_addr_r;
    assign bus.sample_ready    = ready;
    assign bus.sample_rom_data = data_r;
endmodule

// File: tb/tb_sample_rom_ctrl.sv
// Bench for sample_rom_ctrl: SDRAM responder, sample-address model and per-cycle output checker.
`timescale 1ns/1ps
module tb_sample_rom_ctrl;
    localparam int             AW   = 25;
    localparam logic [AW-1:0]  BASE = 25'h010_0000;
    localparam int             LAT  = 5;

    logic CLK_32M = 1'b0;
    logic reset   = 1'b1;
    always #5 CLK_32M = ~CLK_32M;

    sample_rom_ctrl_if #(.ROM_AW(AW)) bus();
    sample_rom_ctrl #(.ROM_AW(AW), .ROM_BASE(BASE)) dut (
        .CLK_32M(CLK_32M),
        .reset  (reset),
        .bus    (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] m_addr = 16'h0000;
    bit          sd_en  = 1'b0;
    bit          inj_ack = 1'b0;
    int          sd_cnt = 0;

    // ROM contents by word-aligned sample address
    function automatic logic [15:0] rom_word(input logic [15:0] wa);
        if (wa == 16'h0000) return 16'hA55A;
        if (wa == 16'h1234) return 16'hBEEF;
        return wa ^ 16'h5AC3;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        logic [15:0] w;
        w = rom_word({a[15:1], 1'b0});
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // SDRAM responder: ack LAT cycles into a request, or a forced stray ack
    initial begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = 16'h0000;
        forever begin
            @(posedge CLK_32M);
            #1;
            bus.rom_ack = 1'b0;
            if (inj_ack) begin
                bus.rom_ack  = 1'b1;
                bus.rom_data = 16'hDEAD;
                inj_ack      = 1'b0;
                sd_cnt       = 0;
            end else if (sd_en && bus.rom_req && !reset) begin
                sd_cnt++;
                if (sd_cnt == LAT) begin
                    bus.rom_ack  = 1'b1;
                    bus.rom_data = rom_word(16'(bus.rom_addr - BASE));
                    sd_cnt       = 0;
                end
            end else begin
                sd_cnt = 0;
            end
        end
    end

    // Per-cycle checker against the address model
    initial begin
        logic          prev_req;
        logic [AW-1:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge CLK_32M);
            if (!reset) begin
                if (bus.sample_ready) begin
                    check("ready_without_req", 32'(bus.rom_req), 32'd0);
                    check("data_vs_model", 32'(bus.sample_rom_data), 32'(exp_byte(m_addr)));
                end
                if (bus.rom_req) begin
                    check("rom_addr_even", 32'(bus.rom_addr[0]), 32'd0);
                    check("rom_addr_in_window", 32'((bus.rom_addr - BASE) >> 16), 32'd0);
                    if (prev_req) check("rom_addr_held", 32'(bus.rom_addr), 32'(prev_addr));
                end
            end
            prev_req  = !reset && bus.rom_req;
            prev_addr = bus.rom_addr;
        end
    end

    task automatic step();
        @(posedge CLK_32M);
        #2;
    endtask

    task automatic mcu_ev(input logic [1:0] wr, input logic [7:0] d, input logic inc);
        logic [15:0] na;
        na = m_addr;
        if (wr == 2'b11)      na = {d, d};
        else if (wr == 2'b01) na = {m_addr[15:8], d};
        else if (wr == 2'b10) na = {d, m_addr[7:0]};
        else if (inc)         na = m_addr + 16'd1;
        bus.sample_addr_wr = wr;
        bus.sample_addr    = d;
        bus.sample_inc     = inc;
        step();
        bus.sample_addr_wr = 2'b00;
        bus.sample_inc     = 1'b0;
        m_addr = na;
    endtask

    task automatic wait_ack(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.rom_ack) break;
        end
        check(name, 32'(bus.rom_ack), 32'd1);
    endtask

    task automatic wait_ready(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.sample_ready) break;
            step();
        end
        check(name, 32'(bus.sample_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_addr_wr = 2'b00;
        bus.sample_addr    = 8'h00;
        bus.sample_inc     = 1'b0;
        sd_en = 1'b1;
        repeat (3) step();
        check("rst_req",      32'(bus.rom_req), 32'd0);
        check("rst_ready",    32'(bus.sample_ready), 32'd0);
        check("rst_data",     32'(bus.sample_rom_data), 32'h00);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'(BASE));

        // reset release: BOOT then fetch of word 0
        reset = 1'b0;
        step();
        check("boot_req",      32'(bus.rom_req), 32'd1);
        check("boot_rom_addr", 32'(bus.rom_addr), 32'(BASE));
        check("boot_ready",    32'(bus.sample_ready), 32'd0);
        wait_ack("boot_ack", 20);
        step();
        check("boot_ready_rise", 32'(bus.sample_ready), 32'd1);
        check("boot_data",       32'(bus.sample_rom_data), 32'h5A);

        // address load, second byte lands while the first fetch is in flight
        mcu_ev(2'b01, 8'h34, 1'b0);
        check("ld_req",   32'(bus.rom_req), 32'd1);
        check("ld_ready", 32'(bus.sample_ready), 32'd0);
        mcu_ev(2'b10, 8'h12, 1'b0);
        wait_ready("ld_done", 60);
        check("ld_data", 32'(bus.sample_rom_data), 32'hEF);

        // increment within the same word
        mcu_ev(2'b00, 8'h00, 1'b1);
`ifdef SAMPLE_WORD_CACHE_EN
        check("inc_hit_req",   32'(bus.rom_req), 32'd0);
        check("inc_hit_ready", 32'(bus.sample_ready), 32'd1);
        check("inc_hit_data",  32'(bus.sample_rom_data), 32'hBE);
`else
        check("inc_req",      32'(bus.rom_req), 32'd1);
        check("inc_rom_addr", 32'(bus.rom_addr), 32'(BASE + 25'h1234));
        check("inc_ready",    32'(bus.sample_ready), 32'd0);
        wait_ready("inc_done", 40);
        check("inc_data", 32'(bus.sample_rom_data), 32'hBE);
`endif

        // wrap FFFF -> 0000
        mcu_ev(2'b11, 8'hFF, 1'b0);
        wait_ready("ffff_done", 40);
        check("ffff_data", 32'(bus.sample_rom_data), 32'hA5);
        mcu_ev(2'b00, 8'h00, 1'b1);
        check("wrap_req",      32'(bus.rom_req), 32'd1);
        check("wrap_rom_addr", 32'(bus.rom_addr), 32'(BASE));
        wait_ready("wrap_done", 40);
        check("wrap_data", 32'(bus.sample_rom_data), 32'h5A);

        // stale: increment into the next word two cycles after rom_req rises
        mcu_ev(2'b01, 8'h21, 1'b0);
        check("stale_req_rise", 32'(bus.rom_req), 32'd1);
        step();
        step();
        mcu_ev(2'b00, 8'h00, 1'b1);
        check("stale_addr_held", 32'(bus.rom_addr), 32'(BASE + 25'h0020));
        wait_ack("stale_ack1", 20);
        check("stale_ready_at_ack1", 32'(bus.sample_ready), 32'd0);
        step();
        check("stale_gap_req",   32'(bus.rom_req), 32'd0);
        check("stale_gap_ready", 32'(bus.sample_ready), 32'd0);
        step();
        check("stale_rereq",          32'(bus.rom_req), 32'd1);
        check("stale_rereq_rom_addr", 32'(bus.rom_addr), 32'(BASE + 25'h0022));
        check("stale_rereq_ready",    32'(bus.sample_ready), 32'd0);
        wait_ack("stale_ack2", 20);
        check("stale_ready_at_ack2", 32'(bus.sample_ready), 32'd0);
        step();
        check("stale_ready", 32'(bus.sample_ready), 32'd1);
        check("stale_data",  32'(bus.sample_rom_data), 32'hE1);

        // reset mid-fetch, stray ack during BOOT
        mcu_ev(2'b11, 8'h55, 1'b0);
        check("rr_req", 32'(bus.rom_req), 32'd1);
        step();
        reset  = 1'b1;
        m_addr = 16'h0000;
        #1;
        check("rr_req_async",  32'(bus.rom_req), 32'd0);
        check("rr_ready",      32'(bus.sample_ready), 32'd0);
        check("rr_rom_addr",   32'(bus.rom_addr), 32'(BASE));
        check("rr_data",       32'(bus.sample_rom_data), 32'h00);
        step();
        inj_ack = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rr_boot_req",      32'(bus.rom_req), 32'd1);
        check("rr_boot_rom_addr", 32'(bus.rom_addr), 32'(BASE));
        check("rr_boot_ready",    32'(bus.sample_ready), 32'd0);
        wait_ack("rr_ack", 20);
        step();
        check("rr_ready_rise", 32'(bus.sample_ready), 32'd1);
        check("rr_final_data", 32'(bus.sample_rom_data), 32'h5A);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
